// File: rtl/cpu_types_pkg.sv
// Shared enums for the memory-side datapath: RAM status codes and arbiter grant states.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_txn_timer.sv
// Per-transaction wait counter; o_expired flags the last tolerated wait cycle (TIMEOUT-1).
module arb_txn_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_clr)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_expired = (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Instruction/data arbiter for the single RAM port, data-priority with bounded instruction starvation.
// Optional grant/abort statistics outputs are enabled by defining ARB_STATS_EN.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic [31:0] iload,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        err,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
`ifdef ARB_STATS_EN
  ,
  output logic [31:0] igrants,
  output logic [31:0] dgrants,
  output logic [31:0] errcount
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_t    r_state;
  logic [31:0]   r_addr;
  logic [31:0]   r_store;
  logic          r_wr;
  logic [SW-1:0] r_starve;

  ramstate_t w_rs;
  logic      w_granted;
  logic      w_wait;
  logic      w_done;
  logic      w_abort;
  logic      w_expired;
  logic      w_dreq;
  logic      w_istarved;

  assign w_rs       = ramstate_t'(ramstate);
  assign w_granted  = (r_state != IDLE);
  assign w_wait     = w_granted && ((w_rs == FREE) || (w_rs == BUSY));
  assign w_done     = w_granted && (w_rs == ACCESS);
  assign w_abort    = w_granted && ((w_rs == ERROR) || (w_wait && w_expired));
  assign w_dreq     = dREN || dWEN;
  assign w_istarved = iREN && (r_starve == SW'(STARVE_LIMIT));

  arb_txn_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .i_clk     (CLK),
    .i_clr     (RST || !w_granted),
    .i_en      (w_wait),
    .o_expired (w_expired)
  );

  // Strobes are suppressed in a reset cycle so a dropped transaction never reports.
  always_comb begin
    ihit     = !RST && w_done && (r_state == IGNT);
    dhit     = !RST && w_done && (r_state == DGNT);
    err      = !RST && w_abort;
    iload    = ihit ? ramload : '0;
    dload    = (dhit && !r_wr) ? ramload : '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (w_granted) begin
      ramaddr = r_addr;
      ramWEN  = (r_state == DGNT) && r_wr;
      ramREN  = !ramWEN;
      if (ramWEN)
        ramstore = r_store;
    end
  end

`ifdef ARB_STATS_EN
  logic [31:0] r_igrants;
  logic [31:0] r_dgrants;
  logic [31:0] r_errcount;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_igrants  <= '0;
      r_dgrants  <= '0;
      r_errcount <= '0;
    end else begin
      if (r_state == IDLE && w_dreq && !w_istarved)
        r_dgrants <= r_dgrants + 32'd1;
      else if (r_state == IDLE && iREN)
        r_igrants <= r_igrants + 32'd1;
      if (w_abort)
        r_errcount <= r_errcount + 32'd1;
    end
  end

  assign igrants  = r_igrants;
  assign dgrants  = r_dgrants;
  assign errcount = r_errcount;
`endif

  // Grant FSM; the entry edge latches the winner's address, store data and direction.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_starve <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_dreq && !w_istarved) begin
            r_state <= DGNT;
            r_addr  <= daddr;
            r_store <= dstore;
            r_wr    <= dWEN;
            if (!iREN)
              r_starve <= '0;
            else if (r_starve != SW'(STARVE_LIMIT))
              r_starve <= r_starve + 1'b1;
          end else if (iREN) begin
            r_state  <= IGNT;
            r_addr   <= iaddr;
            r_store  <= '0;
            r_wr     <= 1'b0;
            r_starve <= '0;
          end else begin
            r_starve <= '0;
          end
        end
        IGNT, DGNT: begin
          if (w_done || w_abort)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter against a transaction-level arbitration model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int STARVE = 4;
  localparam int TMO    = 64;
  localparam int NCYC   = 3000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        ihit, dhit, err;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
`ifdef ARB_STATS_EN
  logic [31:0] igrants, dgrants, errcount;
`endif

  always #5 CLK = ~CLK;

  mem_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload), .err(err),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
`ifdef ARB_STATS_EN
    , .igrants(igrants), .dgrants(dgrants), .errcount(errcount)
`endif
  );

  typedef struct {
    int          cyc;
    logic        ih;
    logic        dh;
    logic        er;
    logic [31:0] il;
    logic [31:0] dl;
  } strobe_t;

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
  } ramexp_t;

  strobe_t sq[$];
  ramexp_t rq[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Reference model state: who owns the RAM, what was latched, and how this transaction ends.
  int          m_own;   // 0 none, 1 instruction, 2 data
  logic        m_wr;
  logic [31:0] m_addr, m_store;
  int          m_k, m_wait, m_plan;   // plan 0 access, 1 error, 2 stuck busy
  int          starve;
  int          m_igr, m_dgr, m_ec;
  bit          i_done, d_done, rst_now, cont, term;
  int          sel, rsel;
  logic [1:0]  rs;
  strobe_t     se;
  ramexp_t     re;

  initial begin
    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = 2'd0;
    m_own = 0; m_wr = 1'b0; m_addr = '0; m_store = '0; m_k = 0; m_wait = 0; m_plan = 0;
    starve = 0; m_igr = 0; m_dgr = 0; m_ec = 0; i_done = 0; d_done = 0;

    for (int n = 0; n < NCYC + 80; n++) begin
      @(posedge CLK); #1;
      rst_now = (n < 3) || ($urandom_range(0, 199) == 0);
      cont    = (n >= 1000 && n < 1500);
      if (n >= NCYC) begin
        // drain: no new requests once the current ones complete
        if (i_done) iREN = 1'b0;
        if (d_done) begin dREN = 1'b0; dWEN = 1'b0; end
      end else begin
        if (i_done || !iREN) iREN = cont ? 1'b1 : ($urandom_range(0, 2) != 0);
        if (d_done || !(dREN || dWEN)) begin
          sel  = cont ? (1 + $urandom_range(0, 1)) : $urandom_range(0, 3);
          dREN = (sel == 1) || (sel == 3);
          dWEN = (sel == 2);
        end
      end
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;

      term = 0;
      rs   = 2'($urandom_range(0, 3));
      if (m_own != 0) begin
        if (m_plan == 2 || m_k < m_wait) begin
          rs   = 2'($urandom_range(0, 1));
          term = (m_k == TMO - 1);
        end else begin
          rs   = (m_plan == 0) ? 2'd2 : 2'd3;
          term = 1;
        end
      end
      ramstate = rs;
      RST      = rst_now;

      re.ren = 1'b0; re.wen = 1'b0; re.addr = '0; re.store = '0;
      if (m_own != 0) begin
        re.wen   = (m_own == 2) && m_wr;
        re.ren   = !re.wen;
        re.addr  = m_addr;
        re.store = re.wen ? m_store : 32'h0;
      end
      rq.push_back(re);

      i_done = 0; d_done = 0;
      if (m_own != 0 && term && !rst_now) begin
        se.cyc = cyc;
        se.er  = (rs != 2'd2);
        se.ih  = (m_own == 1) && !se.er;
        se.dh  = (m_own == 2) && !se.er;
        se.il  = se.ih ? ramload : 32'h0;
        se.dl  = (se.dh && !m_wr) ? ramload : 32'h0;
        sq.push_back(se);
        i_done = se.ih; d_done = se.dh;
        if (se.er) m_ec++;
      end

      if (rst_now) begin
        m_own = 0; starve = 0; m_igr = 0; m_dgr = 0; m_ec = 0;
      end else if (m_own == 0) begin
        if ((dREN || dWEN) && !(iREN && starve == STARVE)) begin
          m_own = 2; m_wr = dWEN; m_addr = daddr; m_store = dstore; m_dgr++;
          starve = iREN ? ((starve < STARVE) ? starve + 1 : starve) : 0;
        end else if (iREN) begin
          m_own = 1; m_wr = 1'b0; m_addr = iaddr; starve = 0; m_igr++;
        end else begin
          starve = 0;
        end
        if (m_own != 0) begin
          m_k  = 0;
          rsel = $urandom_range(0, 99);
          if (rsel < 55)      begin m_plan = 0; m_wait = 0; end
          else if (rsel < 85) begin m_plan = 0; m_wait = $urandom_range(1, 3); end
          else if (rsel < 96) begin m_plan = 1; m_wait = $urandom_range(0, 2); end
          else                begin m_plan = 2; m_wait = 0; end
        end
      end else if (term) begin
        m_own = 0;
      end else begin
        m_k++;
      end
    end

    @(negedge CLK); #1;
    checks++;
    if (sq.size() != 0) begin
      errors++;
      $display("FAIL pending_strobes got %0d outstanding want 0", sq.size());
    end
`ifdef ARB_STATS_EN
    checks++;
    if (igrants !== 32'(m_igr) || dgrants !== 32'(m_dgr) || errcount !== 32'(m_ec)) begin
      errors++;
      $display("FAIL stats got %0d/%0d/%0d want %0d/%0d/%0d",
               igrants, dgrants, errcount, m_igr, m_dgr, m_ec);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  strobe_t me;
  ramexp_t mr;

  initial begin
    forever begin
      @(negedge CLK);
      if (rq.size() > 0) begin
        mr = rq.pop_front();
        checks++;
        if (ramREN !== mr.ren || ramWEN !== mr.wen || ramaddr !== mr.addr || ramstore !== mr.store) begin
          errors++;
          $display("FAIL ram_drive cyc=%0d got ren=%b wen=%b addr=%h store=%h want ren=%b wen=%b addr=%h store=%h",
                   cyc, ramREN, ramWEN, ramaddr, ramstore, mr.ren, mr.wen, mr.addr, mr.store);
        end
      end
      while (sq.size() > 0 && sq[0].cyc < cyc) begin
        me = sq.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_strobe at cyc=%0d got none want ih=%b dh=%b er=%b", me.cyc, me.ih, me.dh, me.er);
      end
      if (ihit || dhit || err) begin
        checks++;
        if (sq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe cyc=%0d got ih=%b dh=%b er=%b want none", cyc, ihit, dhit, err);
        end else begin
          me = sq.pop_front();
          if (me.cyc != cyc || ihit !== me.ih || dhit !== me.dh || err !== me.er ||
              iload !== me.il || dload !== me.dl) begin
            errors++;
            $display("FAIL strobe cyc=%0d got ih=%b dh=%b er=%b il=%h dl=%h want cyc=%0d ih=%b dh=%b er=%b il=%h dl=%h",
                     cyc, ihit, dhit, err, iload, dload, me.cyc, me.ih, me.dh, me.er, me.il, me.dl);
          end
        end
      end
      if ((!ihit && iload !== 32'h0) || (!dhit && dload !== 32'h0)) begin
        checks++;
        errors++;
        $display("FAIL load_without_hit cyc=%0d got iload=%h dload=%h want 0", cyc, iload, dload);
      end
    end
  end

endmodule
